txtrigger_seq_mc: RTL and testbench
===================================

Name: txtrigger_seq_mc

Overview:
- Parametrised multi-channel successor of the single-channel transmit trigger controller.
- After a start request, waits CKINI clocks, then issues NPER one-cycle trigger pulses spaced CKPER clocks apart.
- Pulses go to a masked set of NCH channels. Adds continuous mode, abort, pulse index and a done strobe.
- Sits between the control register bank and the per-channel transmitter front ends; runs on the 100 MHz master clock.

Parameters:
- NCH, 4, number of trigger output channels (1..16).
- CNT_W, 10, width of the CKINI and CKPER cycle counts.
- NPER_W, 5, width of the NPER pulse count and pulse_idx.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous stop of a running sequence.
- CKINI  in  CNT_W  initial delay in clocks.
- CKPER  in  CNT_W  pulse period in clocks.
- NPER  in  NPER_W  number of pulses.
- chmask  in  NCH  channel enable mask.
- continuous  in  1  1 = repeat forever; NPER is ignored.
- txtrigger  out  NCH  per-channel one-cycle trigger pulses.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle end-of-sequence strobe.
- pulse_idx  out  NPER_W  index of the current or last pulse, wraps modulo 2^NPER_W.

Behaviour:
- All outputs are registered. While reset=0: state=IDLE, txtrigger=0, busy=0, done=0, pulse_idx=0, all counters=0. Reset mid-sequence aborts immediately, with no done strobe.
- States: IDLE, INIT, PER, FIN.
- IDLE, start=1 at edge t0:
  - latch CKINI, CKPER (0 is treated as 1), NPER, chmask, continuous.
  - busy=1 from t0.
  - If NPER=0 and continuous=0, go to FIN.
  - Otherwise go to INIT.
- INIT:
  - Counts the latched CKINI.
  - The first pulse is asserted in the cycle beginning at edge t0+CKINI+1.
  - CKINI=0 puts the first pulse in the cycle after t0. Then go to PER.
- PER:
  - Pulse k (0-based) occupies the cycle beginning at edge t0+CKINI+1+k*CKPER. txtrigger = latched chmask for exactly one cycle; pulse_idx=k in that cycle and holds until the next pulse.
  - After pulse NPER-1 (non-continuous), go to FIN.
  - In continuous mode, pulse_idx wraps to 0 after 2^NPER_W-1.
- FIN:
  - done=1 for exactly one cycle; busy falls in the same cycle; return to IDLE.
  - done occurs CKPER cycles after the last pulse, i.e. the sequence spans its full last period. For NPER=0 it occurs at t0+1.
- abort=1 in INIT or PER: go to FIN at the next edge and suppress any pulse scheduled for that edge. done still pulses.
- abort is ignored in IDLE and FIN. Simultaneous abort and start in IDLE: start wins.
- start while busy is ignored. Input changes while busy have no effect (latched copies are used).
- chmask=0: timing is unchanged, txtrigger stays 0.

Optional Feature:
- Macro: TXTRIG_ROUNDROBIN_EN.
- Defined:
  - Adds input port rr (1 bit), latched at start.
  - rr=1: each pulse drives only the next enabled channel in ascending order, wrapping around, starting from the lowest set bit of chmask.
  - rr=0: broadcast.
  - chmask=0 with rr=1: no pulses, timing unchanged.
- Not defined: rr port is absent; broadcast always.

Test Plan:
- Reset 0 held for 2 cycles mid-run (CKINI=5, CKPER=4, NPER=6) -> all outputs 0 immediately, IDLE, no done.
- CKINI=3, CKPER=4, NPER=3, chmask=4'b1011 -> txtrigger=1011 at t0+4, t0+8, t0+12; pulse_idx 0,1,2; done at t0+16; busy high t0..t0+15.
- CKINI=0, CKPER=0, NPER=2 -> pulses at t0+1 and t0+2 (period treated as 1); done at t0+3.
- NPER=0, continuous=0 -> no pulse, done and busy=0 at t0+1.
- continuous=1, CKINI=1, CKPER=2, NPER_W=2 -> pulse_idx 0,1,2,3,0 …; abort coincident with the 6th pulse edge -> that pulse suppressed, done one cycle, back to IDLE; start during busy ignored.
- TXTRIG_ROUNDROBIN_EN, rr=1, chmask=4'b0110, NPER=4 -> txtrigger 0010, 0100, 0010, 0100.

Source files
------------

// File: rtl/txtrigger_seq_mc.sv
// Multi-channel transmit trigger sequencer: initial delay, then NPER pulses spaced CKPER clocks apart to masked channels.
// Latency: first pulse registered CKINI+1 clocks after start is taken; done strobe one full period after the last pulse.
// No backpressure: start is taken only when idle; abort ends a sequence at the next edge. Optional round-robin via TXTRIG_ROUNDROBIN_EN.
module txtrigger_seq_mc #(
   parameter int NCH    = 4,
   parameter int CNT_W  = 10,
   parameter int NPER_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  CKINI,
   input  logic [CNT_W-1:0]  CKPER,
   input  logic [NPER_W-1:0] NPER,
   input  logic [NCH-1:0]    chmask,
   input  logic              continuous,
`ifdef TXTRIG_ROUNDROBIN_EN
   input  logic              rr,
`endif
   output logic [NCH-1:0]    txtrigger,
   output logic              busy,
   output logic              done,
   output logic [NPER_W-1:0] pulse_idx
);

   typedef enum logic [1:0] {IDLE, INIT, PER, FIN} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   per_q;
   logic [NPER_W-1:0]  nper_q;
   logic [NPER_W-1:0]  nxt_k;
   logic [NCH-1:0]     mask_q;
   logic               cont_q;
   logic               last_q;
   logic               go, fire, fin_exit, last_fire;
   logic [NCH-1:0]     trig_vec;

`ifdef TXTRIG_ROUNDROBIN_EN
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   logic          rr_q, rr_first, rr_found;
   logic [IW-1:0] rr_cur, rr_sel, rr_lo, rr_hi;

   // Pick the next enabled channel above the last one driven, wrapping to the lowest enabled channel
   always_comb begin
      rr_lo    = '0;
      rr_hi    = '0;
      rr_found = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            rr_lo = IW'(i);
            if (!rr_first && (i > int'(rr_cur))) begin
               rr_hi    = IW'(i);
               rr_found = 1'b1;
            end
         end
      end
      rr_sel   = rr_found ? rr_hi : rr_lo;
      trig_vec = rr_q ? ((NCH'(1) << rr_sel) & mask_q) : mask_q;
   end
`else
   assign trig_vec = mask_q;
`endif

   // Next-state logic; FIN is the cycle before done, so done and busy fall together on leaving FIN
   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      fire      = 1'b0;
      fin_exit  = 1'b0;
      last_fire = !cont_q && (nxt_k == nper_q - 1'b1);
      case (state)
         IDLE: begin
            if (start) begin
               go        = 1'b1;
               state_nxt = ((NPER == '0) && !continuous) ? FIN : INIT;
            end
         end
         INIT, PER: begin
            if (abort) begin
               state_nxt = FIN;
            end else if (last_q) begin
               // last pulse already issued: leave so done lands one full period after it
               if (cnt == CNT_W'(1)) state_nxt = FIN;
            end else if (cnt == '0) begin
               fire      = 1'b1;
               state_nxt = (last_fire && (per_q == CNT_W'(1))) ? FIN : PER;
            end
         end
         FIN: begin
            fin_exit  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, latched configuration, counters and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         per_q     <= '0;
         nper_q    <= '0;
         nxt_k     <= '0;
         mask_q    <= '0;
         cont_q    <= 1'b0;
         last_q    <= 1'b0;
         txtrigger <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pulse_idx <= '0;
`ifdef TXTRIG_ROUNDROBIN_EN
         rr_q      <= 1'b0;
         rr_first  <= 1'b0;
         rr_cur    <= '0;
`endif
      end else begin
         state     <= state_nxt;
         txtrigger <= '0;
         done      <= 1'b0;
         if (go) begin
            cnt       <= CKINI;
            per_q     <= (CKPER == '0) ? CNT_W'(1) : CKPER;
            nper_q    <= NPER;
            mask_q    <= chmask;
            cont_q    <= continuous;
            nxt_k     <= '0;
            last_q    <= 1'b0;
            pulse_idx <= '0;
            busy      <= 1'b1;
`ifdef TXTRIG_ROUNDROBIN_EN
            rr_q      <= rr;
            rr_first  <= 1'b1;
`endif
         end else if (fire) begin
            txtrigger <= trig_vec;
            pulse_idx <= nxt_k;
            nxt_k     <= nxt_k + 1'b1;
            last_q    <= last_fire;
            cnt       <= per_q - 1'b1;
`ifdef TXTRIG_ROUNDROBIN_EN
            rr_cur    <= rr_sel;
            rr_first  <= 1'b0;
`endif
         end else if (((state == INIT) || (state == PER)) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (fin_exit) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_txtrigger_seq_mc.sv
module tb_txtrigger_seq_mc;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic       abort = 1'b0;
   logic [9:0] CKINI = '0;
   logic [9:0] CKPER = '0;
   logic [4:0] NPER = '0;
   logic [1:0] NPER2 = '0;
   logic [3:0] chmask = '0;
   logic       continuous = 1'b0;
`ifdef TXTRIG_ROUNDROBIN_EN
   logic       rr_in = 1'b0;
`endif
   logic [3:0] trig1, trig2;
   logic       busy1, busy2, done1, done2;
   logic [4:0] idx1;
   logic [1:0] idx2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] trig;
      logic       busy;
      logic       done;
      int         idx;
      logic       chk_idx;
   } exp_t;

   exp_t exp_q[$];

   always #5 clock = ~clock;

   txtrigger_seq_mc #(.NCH(4), .CNT_W(10), .NPER_W(5)) u_dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .CKINI(CKINI), .CKPER(CKPER), .NPER(NPER), .chmask(chmask),
      .continuous(continuous),
`ifdef TXTRIG_ROUNDROBIN_EN
      .rr(rr_in),
`endif
      .txtrigger(trig1), .busy(busy1), .done(done1), .pulse_idx(idx1)
   );

   txtrigger_seq_mc #(.NCH(4), .CNT_W(10), .NPER_W(2)) u_dut2 (
      .clock(clock), .reset(reset), .start(start2), .abort(abort),
      .CKINI(CKINI), .CKPER(CKPER), .NPER(NPER2), .chmask(chmask),
      .continuous(continuous),
`ifdef TXTRIG_ROUNDROBIN_EN
      .rr(rr_in),
`endif
      .txtrigger(trig2), .busy(busy2), .done(done2), .pulse_idx(idx2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference trigger for pulse k: broadcast, or k-th enabled channel in cyclic ascending order
   function automatic logic [3:0] exp_trig(input logic [3:0] mask, input logic rrv, input int k);
      int bits[4];
      int n = 0;
      logic [3:0] one = 4'b0001;
      for (int i = 0; i < 4; i++) if (mask[i]) begin bits[n] = i; n++; end
      if (!rrv) return mask;
      if (n == 0) return 4'b0000;
      return one << bits[k % n];
   endfunction

   // Push the expected cycle trace, start the selected instance, then pop and compare each cycle
   task automatic run_seq(input int sel, input int ckini, input int ckper, input int nper,
                          input logic [3:0] mask, input logic cont, input int abort_at, input logic rrv);
      int   p, d, w, k, c;
      exp_t e;
      p = (ckper == 0) ? 1 : ckper;
      w = (sel != 0) ? 2 : 5;
      if (abort_at >= 0) d = abort_at + 1;
      else if (nper == 0 && !cont) d = 1;
      else d = ckini + 1 + nper * p;
      for (int cc = 0; cc <= d + 1; cc++) begin
         e.trig = 4'b0000; e.busy = (cc < d); e.done = (cc == d); e.idx = 0; e.chk_idx = 1'b0;
         if (cc >= ckini + 1 && ((cc - ckini - 1) % p) == 0 && !(nper == 0 && !cont)) begin
            k = (cc - ckini - 1) / p;
            if ((cont || k < nper) && (abort_at < 0 || cc < abort_at)) begin
               e.trig = exp_trig(mask, rrv, k);
               e.idx = k % (1 << w);
               e.chk_idx = 1'b1;
            end
         end
         exp_q.push_back(e);
      end
      @(negedge clock);
      CKINI = 10'(ckini); CKPER = 10'(ckper); NPER = 5'(nper); NPER2 = 2'(nper);
      chmask = mask; continuous = cont; abort = 1'b0;
`ifdef TXTRIG_ROUNDROBIN_EN
      rr_in = rrv;
`endif
      if (sel != 0) start2 = 1'b1; else start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; start2 = 1'b0;
      c = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (sel != 0) begin
            chk($sformatf("trig2 c=%0d", c), 32'(trig2), 32'(e.trig));
            chk($sformatf("busy2 c=%0d", c), 32'(busy2), 32'(e.busy));
            chk($sformatf("done2 c=%0d", c), 32'(done2), 32'(e.done));
            if (e.chk_idx) chk($sformatf("idx2 c=%0d", c), 32'(idx2), 32'(e.idx));
         end else begin
            chk($sformatf("trig1 c=%0d", c), 32'(trig1), 32'(e.trig));
            chk($sformatf("busy1 c=%0d", c), 32'(busy1), 32'(e.busy));
            chk($sformatf("done1 c=%0d", c), 32'(done1), 32'(e.done));
            if (e.chk_idx) chk($sformatf("idx1 c=%0d", c), 32'(idx1), 32'(e.idx));
         end
         // While busy, disturb inputs and retry start: latched copies must win
         if (c + 1 <= d) begin
            CKINI = 10'($urandom_range(0, 7)); CKPER = 10'($urandom_range(0, 7));
            NPER = 5'($urandom); NPER2 = 2'($urandom); chmask = 4'($urandom);
            continuous = 1'($urandom);
            if (sel != 0) start2 = 1'($urandom); else start = 1'($urandom);
         end else begin
            start = 1'b0; start2 = 1'b0; continuous = 1'b0;
         end
         abort = (c + 1 == abort_at);
         @(posedge clock); #1;
         c++;
      end
      start = 1'b0; start2 = 1'b0; abort = 1'b0; continuous = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst trig", 32'(trig1), 32'h0);
      chk("rst busy", 32'(busy1), 32'h0);
      chk("rst done", 32'(done1), 32'h0);
      chk("rst idx", 32'(idx1), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);

      run_seq(0, 3, 4, 3, 4'b1011, 1'b0, -1, 1'b0);
      run_seq(0, 0, 0, 2, 4'b1111, 1'b0, -1, 1'b0);
      run_seq(0, 7, 2, 0, 4'b1111, 1'b0, -1, 1'b0);
      run_seq(0, 2, 3, 2, 4'b0000, 1'b0, -1, 1'b0);
      run_seq(1, 1, 2, 3, 4'b0101, 1'b1, 12, 1'b0);
`ifdef TXTRIG_ROUNDROBIN_EN
      run_seq(0, 1, 2, 4, 4'b0110, 1'b0, -1, 1'b1);
      run_seq(1, 0, 1, 3, 4'b1010, 1'b1, 9, 1'b1);
      run_seq(0, 1, 1, 3, 4'b0000, 1'b0, -1, 1'b1);
`endif

      // Asynchronous reset in the middle of a running sequence
      @(negedge clock);
      CKINI = 10'd5; CKPER = 10'd4; NPER = 5'd6; chmask = 4'b1011; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      chk("pre-reset pulse", 32'(trig1), 32'hb);
      #2;
      reset = 1'b0;
      #1;
      chk("async trig", 32'(trig1), 32'h0);
      chk("async busy", 32'(busy1), 32'h0);
      chk("async done", 32'(done1), 32'h0);
      chk("async idx", 32'(idx1), 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock); #1;
         chk($sformatf("post-reset idle %0d", i), {29'h0, trig1 != 4'h0, busy1, done1}, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
